// File: rtl/rv32_id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection for the RV32I core.
// Optional feature: define RV32_FWD_EN to build the EX/MEM and MEM/WB forward muxes.
package rv32_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;
endpackage

module rv32_id_ex_stage
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid_i,
  input  logic [31:0] id_pc_i,
  input  logic [31:0] id_rs1_data_i,
  input  logic [31:0] id_rs2_data_i,
  input  logic [31:0] id_imm_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic [4:0]  id_rd_i,
  input  alu_op_e     id_alu_op_i,
  input  logic        id_use_pc_i,
  input  logic        id_use_imm_i,
  input  logic        id_reg_we_i,
  input  logic        id_mem_read_i,
  input  logic        id_mem_write_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        exmem_valid_i,
  input  logic        exmem_we_i,
  input  logic [4:0]  exmem_rd_i,
  input  logic [31:0] exmem_result_i,
  input  logic        memwb_valid_i,
  input  logic        memwb_we_i,
  input  logic [4:0]  memwb_rd_i,
  input  logic [31:0] memwb_wdata_i,
  output logic        load_use_o,
  output logic        ex_valid_o,
  output logic        ex_reg_we_o,
  output logic        ex_mem_read_o,
  output logic        ex_mem_write_o,
  output logic [31:0] ex_pc_o,
  output logic [4:0]  ex_rd_o,
  output alu_op_e     ex_alu_op_o,
  output logic [31:0] ex_alu_a_o,
  output logic [31:0] ex_alu_b_o,
  output logic [31:0] ex_store_data_o
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic        use_pc;
    logic        use_imm;
    logic        reg_we;
    logic        mem_read;
    logic        mem_write;
  } ex_reg_t;

  ex_reg_t     ex_q, ex_d;
  logic [31:0] fwd_rs1, fwd_rs2;
  logic        exmem_wr, memwb_wr;

  // A writer to x0 never counts as a producer, so index 0 can never match below.
  assign exmem_wr = exmem_valid_i & exmem_we_i & (exmem_rd_i != 5'd0);
  assign memwb_wr = memwb_valid_i & memwb_we_i & (memwb_rd_i != 5'd0);

`ifdef RV32_FWD_EN
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    fwd_rs1 = ex_q.rs1_data;
    fwd_rs2 = ex_q.rs2_data;
    if (exmem_wr && exmem_rd_i == ex_q.rs1)      fwd_rs1 = exmem_result_i;
    else if (memwb_wr && memwb_rd_i == ex_q.rs1) fwd_rs1 = memwb_wdata_i;
    if (exmem_wr && exmem_rd_i == ex_q.rs2)      fwd_rs2 = exmem_result_i;
    else if (memwb_wr && memwb_rd_i == ex_q.rs2) fwd_rs2 = memwb_wdata_i;
  end

  // Only a load in EX cannot be forwarded in time; everything later is covered by the muxes.
  assign load_use_o = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & id_valid_i &
                      ((id_rs1_i == ex_q.rd) | (id_rs2_i == ex_q.rd));
`else
  logic ex_wr;
  logic unused_fwd;

  assign fwd_rs1    = ex_q.rs1_data;
  assign fwd_rs2    = ex_q.rs2_data;
  assign unused_fwd = ^{exmem_result_i, memwb_wdata_i, ex_q.rs1, ex_q.rs2};
  assign ex_wr      = ex_q.valid & ex_q.reg_we & (ex_q.rd != 5'd0);

  // Without forwarding, ID waits until every in-flight producer has written the register file.
  assign load_use_o = id_valid_i & (
      (ex_wr    & ((id_rs1_i == ex_q.rd)    | (id_rs2_i == ex_q.rd)))    |
      (exmem_wr & ((id_rs1_i == exmem_rd_i) | (id_rs2_i == exmem_rd_i))) |
      (memwb_wr & ((id_rs1_i == memwb_rd_i) | (id_rs2_i == memwb_rd_i))));
`endif

  always_comb begin
    ex_d = ex_q;
    if (flush_i) begin
      ex_d.valid     = 1'b0;
      ex_d.reg_we    = 1'b0;
      ex_d.mem_read  = 1'b0;
      ex_d.mem_write = 1'b0;
    end else if (stall_i) begin
      // Capture producers retiring during the stall; they are gone once the stall releases.
      ex_d.rs1_data = fwd_rs1;
      ex_d.rs2_data = fwd_rs2;
    end else if (load_use_o) begin
      ex_d.valid     = 1'b0;
      ex_d.reg_we    = 1'b0;
      ex_d.mem_read  = 1'b0;
      ex_d.mem_write = 1'b0;
    end else begin
      ex_d.valid     = id_valid_i;
      ex_d.pc        = id_pc_i;
      ex_d.rs1       = id_rs1_i;
      ex_d.rs2       = id_rs2_i;
      ex_d.rd        = id_rd_i;
      ex_d.rs1_data  = id_rs1_data_i;
      ex_d.rs2_data  = id_rs2_data_i;
      ex_d.imm       = id_imm_i;
      ex_d.alu_op    = id_alu_op_i;
      ex_d.use_pc    = id_use_pc_i;
      ex_d.use_imm   = id_use_imm_i;
      ex_d.reg_we    = id_reg_we_i;
      ex_d.mem_read  = id_mem_read_i;
      ex_d.mem_write = id_mem_write_i;
    end
  end

  // All-zero reset also yields ALU_ADD, which encodes as 0.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign ex_valid_o      = ex_q.valid;
  assign ex_reg_we_o     = ex_q.valid & ex_q.reg_we;
  assign ex_mem_read_o   = ex_q.valid & ex_q.mem_read;
  assign ex_mem_write_o  = ex_q.valid & ex_q.mem_write;
  assign ex_pc_o         = ex_q.pc;
  assign ex_rd_o         = ex_q.rd;
  assign ex_alu_op_o     = ex_q.alu_op;
  assign ex_alu_a_o      = ex_q.use_pc  ? ex_q.pc  : fwd_rs1;
  assign ex_alu_b_o      = ex_q.use_imm ? ex_q.imm : fwd_rs2;
  assign ex_store_data_o = fwd_rs2;

endmodule

// File: tb/tb_rv32_id_ex_stage.sv
// Directed self-checking bench for rv32_id_ex_stage; expectations follow the RV32_FWD_EN setting.
module tb_rv32_id_ex_stage;
  import rv32_pkg::*;

`ifdef RV32_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk, rst_n;
  logic        id_valid_i;
  logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  alu_op_e     id_alu_op_i;
  logic        id_use_pc_i, id_use_imm_i, id_reg_we_i, id_mem_read_i, id_mem_write_i;
  logic        stall_i, flush_i;
  logic        exmem_valid_i, exmem_we_i, memwb_valid_i, memwb_we_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic [31:0] exmem_result_i, memwb_wdata_i;
  logic        load_use_o, ex_valid_o, ex_reg_we_o, ex_mem_read_o, ex_mem_write_o;
  logic [31:0] ex_pc_o, ex_alu_a_o, ex_alu_b_o, ex_store_data_o;
  logic [4:0]  ex_rd_o;
  alu_op_e     ex_alu_op_o;

  int n_vec = 0;
  int n_err = 0;

  rv32_id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_alu_op_i(id_alu_op_i), .id_use_pc_i(id_use_pc_i), .id_use_imm_i(id_use_imm_i),
    .id_reg_we_i(id_reg_we_i), .id_mem_read_i(id_mem_read_i), .id_mem_write_i(id_mem_write_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .exmem_valid_i(exmem_valid_i), .exmem_we_i(exmem_we_i),
    .exmem_rd_i(exmem_rd_i), .exmem_result_i(exmem_result_i),
    .memwb_valid_i(memwb_valid_i), .memwb_we_i(memwb_we_i),
    .memwb_rd_i(memwb_rd_i), .memwb_wdata_i(memwb_wdata_i),
    .load_use_o(load_use_o), .ex_valid_o(ex_valid_o), .ex_reg_we_o(ex_reg_we_o),
    .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o),
    .ex_pc_o(ex_pc_o), .ex_rd_o(ex_rd_o), .ex_alu_op_o(ex_alu_op_o),
    .ex_alu_a_o(ex_alu_a_o), .ex_alu_b_o(ex_alu_b_o), .ex_store_data_o(ex_store_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_id(input int v, input logic [31:0] pc, input int rs1, input int rs2,
                          input int rd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input alu_op_e op, input int upc,
                          input int uimm, input int we, input int mr, input int mw);
    id_valid_i     = 1'(v);
    id_pc_i        = pc;
    id_rs1_i       = 5'(rs1);
    id_rs2_i       = 5'(rs2);
    id_rd_i        = 5'(rd);
    id_rs1_data_i  = d1;
    id_rs2_data_i  = d2;
    id_imm_i       = imm;
    id_alu_op_i    = op;
    id_use_pc_i    = 1'(upc);
    id_use_imm_i   = 1'(uimm);
    id_reg_we_i    = 1'(we);
    id_mem_read_i  = 1'(mr);
    id_mem_write_i = 1'(mw);
  endtask

  task automatic clear_fwd();
    exmem_valid_i  = 1'b0;
    exmem_we_i     = 1'b0;
    exmem_rd_i     = 5'd0;
    exmem_result_i = 32'h0;
    memwb_valid_i  = 1'b0;
    memwb_we_i     = 1'b0;
    memwb_rd_i     = 5'd0;
    memwb_wdata_i  = 32'h0;
  endtask

  task automatic check_reset(input string p);
    check({p, "_valid"}, 32'(ex_valid_o), 32'h0);
    check({p, "_we"},    32'(ex_reg_we_o), 32'h0);
    check({p, "_mr"},    32'(ex_mem_read_o), 32'h0);
    check({p, "_mw"},    32'(ex_mem_write_o), 32'h0);
    check({p, "_pc"},    ex_pc_o, 32'h0);
    check({p, "_rd"},    32'(ex_rd_o), 32'h0);
    check({p, "_op"},    32'(ex_alu_op_o), 32'(ALU_ADD));
    check({p, "_a"},     ex_alu_a_o, 32'h0);
    check({p, "_b"},     ex_alu_b_o, 32'h0);
    check({p, "_st"},    ex_store_data_o, 32'h0);
    check({p, "_lu"},    32'(load_use_o), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    clear_fwd();
    drive_id(1, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0, ALU_ADD, 0, 0, 0, 0, 0);
    #3;
    check_reset("rst");

    // Plain register-register instruction
    @(negedge clk); rst_n = 1'b1;
    drive_id(1, 32'h100, 1, 2, 3, 32'h10, 32'h20, 32'h4, ALU_SUB, 0, 0, 1, 0, 0);
    @(negedge clk); #1;
    check("ld_valid", 32'(ex_valid_o), 32'h1);
    check("ld_pc", ex_pc_o, 32'h100);
    check("ld_rd", 32'(ex_rd_o), 32'h3);
    check("ld_op", 32'(ex_alu_op_o), 32'(ALU_SUB));
    check("ld_a", ex_alu_a_o, 32'h10);
    check("ld_b", ex_alu_b_o, 32'h20);
    check("ld_st", ex_store_data_o, 32'h20);
    check("ld_we", 32'(ex_reg_we_o), 32'h1);
    check("ld_mr", 32'(ex_mem_read_o), 32'h0);

    // PC / immediate operand select
    drive_id(1, 32'h200, 4, 5, 6, 32'h77, 32'h99, 32'h7FC, ALU_ADD, 1, 1, 1, 0, 1);
    @(negedge clk); #1;
    check("imm_a", ex_alu_a_o, 32'h200);
    check("imm_b", ex_alu_b_o, 32'h7FC);
    check("imm_st", ex_store_data_o, 32'h99);
    check("imm_mw", 32'(ex_mem_write_o), 32'h1);

    // EX/MEM priority over MEM/WB
    drive_id(1, 32'h300, 5, 0, 8, 32'h1111, 32'h0, 32'h0, ALU_ADD, 0, 0, 1, 0, 0);
    @(negedge clk); #1;
    exmem_valid_i = 1'b1; exmem_we_i = 1'b1; exmem_rd_i = 5'd5; exmem_result_i = 32'hAAAA;
    memwb_valid_i = 1'b1; memwb_we_i = 1'b1; memwb_rd_i = 5'd5; memwb_wdata_i = 32'hBBBB;
    #1;
    check("fwd_exmem_a", ex_alu_a_o, FWD ? 32'hAAAA : 32'h1111);
    check("fwd_lu", 32'(load_use_o), FWD ? 32'h0 : 32'h1);
    exmem_we_i = 1'b0;
    #1;
    check("fwd_memwb_a", ex_alu_a_o, FWD ? 32'hBBBB : 32'h1111);

    // x0 never forwards
    clear_fwd();
    drive_id(1, 32'h400, 0, 0, 10, 32'h0, 32'h0, 32'h0, ALU_ADD, 0, 0, 1, 0, 0);
    @(negedge clk); #1;
    exmem_valid_i = 1'b1; exmem_we_i = 1'b1; exmem_rd_i = 5'd0; exmem_result_i = 32'hFFFF_FFFF;
    memwb_valid_i = 1'b1; memwb_we_i = 1'b1; memwb_rd_i = 5'd0; memwb_wdata_i = 32'hFFFF_FFFF;
    #1;
    check("x0_a", ex_alu_a_o, 32'h0);
    check("x0_st", ex_store_data_o, 32'h0);
    check("x0_lu", 32'(load_use_o), 32'h0);
    clear_fwd();

    // Load-use: lw x3, 8(x2) followed by add x4, x3, x3
    drive_id(1, 32'h500, 2, 0, 3, 32'h1000, 32'h0, 32'h8, ALU_ADD, 0, 1, 1, 1, 0);
    @(negedge clk); #1;
    drive_id(1, 32'h504, 3, 3, 4, 32'hDEAD, 32'hDEAD, 32'h0, ALU_ADD, 0, 0, 1, 0, 0);
    #1;
    check("lu_t0", 32'(load_use_o), 32'h1);
    check("lu_mr", 32'(ex_mem_read_o), 32'h1);
    check("lu_a", ex_alu_a_o, 32'h1000);
    check("lu_b", ex_alu_b_o, 32'h8);
    @(negedge clk); #1;
    check("lu_bubble", 32'(ex_valid_o), 32'h0);
    check("lu_bubble_we", 32'(ex_reg_we_o), 32'h0);
    exmem_valid_i = 1'b1; exmem_we_i = 1'b1; exmem_rd_i = 5'd3; exmem_result_i = 32'h1008;
    #1;
`ifdef RV32_FWD_EN
    check("lu_t1", 32'(load_use_o), 32'h0);
    @(negedge clk); #1;
    exmem_valid_i = 1'b0;
    memwb_valid_i = 1'b1; memwb_we_i = 1'b1; memwb_rd_i = 5'd3; memwb_wdata_i = 32'hCAFE;
    #1;
    check("lu_t2_valid", 32'(ex_valid_o), 32'h1);
    check("lu_t2_rd", 32'(ex_rd_o), 32'h4);
    check("lu_t2_a", ex_alu_a_o, 32'hCAFE);
    check("lu_t2_b", ex_alu_b_o, 32'hCAFE);
    check("lu_t2_lu", 32'(load_use_o), 32'h0);
`else
    check("lu_t1", 32'(load_use_o), 32'h1);
    @(negedge clk); #1;
    check("lu_t2_valid", 32'(ex_valid_o), 32'h0);
    exmem_valid_i = 1'b0;
    memwb_valid_i = 1'b1; memwb_we_i = 1'b1; memwb_rd_i = 5'd3; memwb_wdata_i = 32'hCAFE;
    #1;
    check("lu_t2_lu", 32'(load_use_o), 32'h1);
    @(negedge clk); #1;
    check("lu_t3_valid", 32'(ex_valid_o), 32'h0);
    memwb_valid_i = 1'b0;
    id_rs1_data_i = 32'hCAFE; id_rs2_data_i = 32'hCAFE;
    #1;
    check("lu_t3_lu", 32'(load_use_o), 32'h0);
    @(negedge clk); #1;
    check("lu_t4_valid", 32'(ex_valid_o), 32'h1);
    check("lu_t4_rd", 32'(ex_rd_o), 32'h4);
    check("lu_t4_a", ex_alu_a_o, 32'hCAFE);
    check("lu_t4_b", ex_alu_b_o, 32'hCAFE);
`endif
    clear_fwd();

    // Stall refresh: x7 = 0x55 retires from MEM/WB during the first stall cycle only
    drive_id(1, 32'h600, 7, 0, 9, 32'h0, 32'h0, 32'h0, ALU_OR, 0, 0, 1, 0, 0);
    @(negedge clk); #1;
    check("sr_pc", ex_pc_o, 32'h600);
    stall_i = 1'b1;
    memwb_valid_i = 1'b1; memwb_we_i = 1'b1; memwb_rd_i = 5'd7; memwb_wdata_i = 32'h55;
    drive_id(1, 32'h999, 1, 2, 11, 32'h3, 32'h4, 32'h0, ALU_XOR, 0, 0, 1, 0, 0);
    @(negedge clk); #1;
    memwb_valid_i = 1'b0;
    #1;
    check("sr_hold_pc", ex_pc_o, 32'h600);
    check("sr_c2_a", ex_alu_a_o, FWD ? 32'h55 : 32'h0);
    @(negedge clk); #1;
    stall_i = 1'b0;
    #1;
    check("sr_rel_a", ex_alu_a_o, FWD ? 32'h55 : 32'h0);
    check("sr_rel_op", 32'(ex_alu_op_o), 32'(ALU_OR));
    @(negedge clk); #1;
    check("sr_next_pc", ex_pc_o, 32'h999);
    check("sr_next_op", 32'(ex_alu_op_o), 32'(ALU_XOR));
    check("sr_next_a", ex_alu_a_o, 32'h3);

    // Flush wins over stall
    flush_i = 1'b1; stall_i = 1'b1;
    drive_id(1, 32'hAAA, 1, 1, 1, 32'h0, 32'h0, 32'h0, ALU_SUB, 0, 0, 1, 0, 0);
    @(negedge clk); #1;
    flush_i = 1'b0; stall_i = 1'b0;
    check("fl_valid", 32'(ex_valid_o), 32'h0);
    check("fl_we", 32'(ex_reg_we_o), 32'h0);
    check("fl_pc_hold", ex_pc_o, 32'h999);

    // Asynchronous reset with a valid instruction in EX
    drive_id(1, 32'hB00, 12, 13, 14, 32'h12, 32'h34, 32'h0, ALU_AND, 0, 0, 1, 0, 1);
    #1;
    check("pre_rst_lu", 32'(load_use_o), 32'h0);
    @(negedge clk); #1;
    check("pre_rst_valid", 32'(ex_valid_o), 32'h1);
    check("pre_rst_pc", ex_pc_o, 32'hB00);
    rst_n = 1'b0;
    #1;
    check_reset("arst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv32_id_ex_stage.md
# rv32_id_ex_stage

ID/EX pipeline register and execute-operand selection for the 5-stage RV32I core. Captures decoded instructions from ID, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and drives `op`/`a`/`b` of `rv32_alu` plus store data. Detects load-use hazards, requests an ID stall and inserts a bubble into EX.

## Interface
Parameters:
- none; widths are fixed RV32: XLEN 32, register index 5.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `id_valid_i` in 1: ID holds a valid instruction.
- `id_pc_i`, `id_rs1_data_i`, `id_rs2_data_i`, `id_imm_i` in 32 each: PC, register-file read data, immediate.
- `id_rs1_i`, `id_rs2_i`, `id_rd_i` in 5 each: source and destination indices.
- `id_alu_op_i` in `rv32_pkg::alu_op_e`: ALU operation.
- `id_use_pc_i`, `id_use_imm_i` in 1 each: operand A = PC; operand B = immediate.
- `id_reg_we_i`, `id_mem_read_i`, `id_mem_write_i` in 1 each: writeback, load, store.
- `stall_i` in 1: downstream stall; EX holds.
- `flush_i` in 1: squash the instruction entering EX (branch redirect).
- `exmem_valid_i`, `exmem_we_i` in 1 each; `exmem_rd_i` in 5; `exmem_result_i` in 32: EX/MEM forward source.
- `memwb_valid_i`, `memwb_we_i` in 1 each; `memwb_rd_i` in 5; `memwb_wdata_i` in 32: MEM/WB forward source.
- `load_use_o` out 1: combinational; ID must hold and not advance.
- `ex_valid_o`, `ex_reg_we_o`, `ex_mem_read_o`, `ex_mem_write_o` out 1 each: registered controls, each ANDed with valid.
- `ex_pc_o` out 32; `ex_rd_o` out 5: registered.
- `ex_alu_op_o` out `alu_op_e`; `ex_alu_a_o`, `ex_alu_b_o`, `ex_store_data_o` out 32: to ALU/MEM.

## Operation
- EX register update priority per cycle: reset > `flush_i` > `stall_i` > `load_use_o` > normal load.
- Normal load: all `id_*` fields captured; valid = `id_valid_i`.
- `flush_i` (also while `stall_i`): valid, reg_we, mem_read, mem_write cleared; other fields hold.
- `stall_i`: all fields hold, except stored rs1/rs2 data is overwritten by the forwarded values, so a producer retiring from WB during the stall is not lost.
- `load_use_o` without stall/flush: EX loads a bubble (valid 0, controls 0); ID holds the consumer.
- `load_use_o` = `ex_valid_o & ex_mem_read_o & ex_rd_o!=0 & id_valid_i & (id_rs1_i==ex_rd_o | id_rs2_i==ex_rd_o)`; conservative, ignores whether ID uses the operand.
- Forwarding per operand from stored rs index/data: EX/MEM match (`exmem_valid_i & exmem_we_i & exmem_rd_i!=0 & rd==rs`) wins over MEM/WB match; otherwise stored data. Index 0 never forwards and reads stored data.
- `ex_alu_a_o` = use_pc ? pc : fwd_rs1; `ex_alu_b_o` = use_imm ? imm : fwd_rs2; `ex_store_data_o` = fwd_rs2 always.

## Timing
- Latency: ID inputs at edge N appear on `ex_*` after edge N; operand muxing is combinational off the register, with forward inputs sampled the same cycle.
- Reset (async assert, sync-deasserted upstream): all registered fields 0, `ex_alu_op_o` = `ALU_ADD`, `ex_valid_o` 0; `load_use_o` 0.
- Load-use sequence: cycle t load in EX and consumer in ID gives `load_use_o`=1; t+1 bubble in EX, `load_use_o`=0; t+2 consumer in EX with load forwarded from MEM/WB.
- `load_use_o` does not depend on `stall_i` or `flush_i`; the upstream combines them.
- Reset mid-stall: state clears immediately; the pending instruction is lost.

## Configuration
- `RV32_FWD_EN` defined: forwarding as above.
- Undefined: no forward muxes; operands come from stored data. `load_use_o` widens to any valid, writing, rd!=0 match against EX, EX/MEM or MEM/WB, regardless of the load bit. The register file must be write-before-read.

## Test plan
- Reset: with `rst_n`=0 mid-traffic, all outputs 0 and op=`ALU_ADD` asynchronously, before the next edge.
- EX/MEM over MEM/WB: stored rs1 `32'h1111`, exmem rd 5 = `32'hAAAA`, memwb rd 5 = `32'hBBBB`, rs1=5 gives a=`32'hAAAA`; with exmem_we=0, a=`32'hBBBB`.
- x0: rs1=0 with exmem rd 0 = `32'hFFFF_FFFF` gives a = stored value `32'h0`.
- Load-use: `lw x3` in EX, `add x4,x3,x3` in ID gives `load_use_o`=1 for one cycle, then a bubble (`ex_valid_o`=0), then add in EX with a=b=memwb_wdata.
- Stall refresh: `stall_i`=1 for 2 cycles while x7=`32'h55` retires via MEM/WB in cycle 1 only; after release, a=`32'h55`.
- Flush with stall: both `flush_i` and `stall_i` asserted gives `ex_valid_o`=0 and `ex_reg_we_o`=0 next cycle.
